// File: rtl/cnn_layer_accel_seq_pkg.sv
// Shared types and Gray phase constants for the weight sequence generator and table.
package cnn_layer_accel_seq_pkg;

  localparam int unsigned SEQ_ADDR_W = 3;
  localparam int unsigned GRAY_W     = 2;

  localparam logic [GRAY_W-1:0] GRAY_P0 = 2'b00;
  localparam logic [GRAY_W-1:0] GRAY_P1 = 2'b01;
  localparam logic [GRAY_W-1:0] GRAY_P2 = 2'b11;
  localparam logic [GRAY_W-1:0] GRAY_P3 = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Phase order 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [GRAY_W-1:0] next_gray(input logic [GRAY_W-1:0] g);
    next_gray = GRAY_P0;
    case (g)
      GRAY_P0: next_gray = GRAY_P1;
      GRAY_P1: next_gray = GRAY_P2;
      GRAY_P2: next_gray = GRAY_P3;
      default: next_gray = GRAY_P0;
    endcase
  endfunction

endpackage

// File: rtl/cnn_layer_accel_gray_cnt2.sv
// 2-bit Gray-code phase counter with synchronous load and enable.
module cnn_layer_accel_gray_cnt2
  import cnn_layer_accel_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [GRAY_W-1:0] load_val,
  input  logic              en,
  output logic [GRAY_W-1:0] gray
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gray <= GRAY_P0;
    end else if (load) begin
      gray <= load_val;
    end else if (en) begin
      gray <= next_gray(gray);
    end
  end

endmodule

// File: rtl/cnn_layer_accel_weight_sequence_gen.sv
// Walks Gray phases and per-phase sequence addresses to drive the weight sequence table.
module cnn_layer_accel_weight_sequence_gen
  import cnn_layer_accel_seq_pkg::*;
#(
  parameter int unsigned C_SEQ_LEN     = 5,
  parameter int unsigned C_PHASE_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [C_PHASE_CNT_W-1:0] cfg_num_phases,
  input  logic [1:0]               cfg_start_gray,
  input  logic                     abort,
  input  logic                     seq_ready,
  output logic [1:0]               gray_code,
  output logic [2:0]               seq_data_addr,
  output logic                     seq_valid,
  output logic                     wht_valid,
  output logic                     busy,
  output logic                     done
);

  if ((C_SEQ_LEN < 1) || (C_SEQ_LEN > 8)) begin : g_bad_seq_len
    $error("C_SEQ_LEN must be in 1..8");
  end

  localparam logic [SEQ_ADDR_W-1:0]    LAST_ADDR = SEQ_ADDR_W'(C_SEQ_LEN - 1);
  localparam logic [C_PHASE_CNT_W-1:0] ONE_PHASE = C_PHASE_CNT_W'(1);

  state_t                   state_q, state_d;
  logic [SEQ_ADDR_W-1:0]    addr_d;
  logic [C_PHASE_CNT_W-1:0] phase_cnt_q, phase_cnt_d;
  logic                     seq_valid_d, busy_d, done_d, wht_valid_d;
  logic                     gray_load, gray_en;
  logic                     hs;

  cnn_layer_accel_gray_cnt2 u_gray (
    .clk      (clk),
    .rst      (rst),
    .load     (gray_load),
    .load_val (cfg_start_gray),
    .en       (gray_en),
    .gray     (gray_code)
  );

  // Next state, counter updates and registered-output next values.
  always_comb begin
    state_d     = state_q;
    addr_d      = seq_data_addr;
    phase_cnt_d = phase_cnt_q;
    gray_load   = 1'b0;
    gray_en     = 1'b0;
    hs          = seq_valid & seq_ready & ~abort;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_num_phases != '0) begin
            state_d     = RUN;
            gray_load   = 1'b1;
            addr_d      = '0;
            phase_cnt_d = cfg_num_phases;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (hs) begin
          if (seq_data_addr == LAST_ADDR) begin
            // Final address of the final phase: hold gray/addr at their last values.
            if (phase_cnt_q == ONE_PHASE) begin
              state_d = DONE;
            end else begin
              addr_d      = '0;
              gray_en     = 1'b1;
              phase_cnt_d = phase_cnt_q - ONE_PHASE;
            end
          end else begin
            addr_d = seq_data_addr + SEQ_ADDR_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    seq_valid_d = (state_d == RUN);
    busy_d      = (state_d == RUN);
    done_d      = (state_d == DONE);
    wht_valid_d = hs;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_data_addr <= '0;
      phase_cnt_q   <= '0;
      seq_valid     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      wht_valid     <= 1'b0;
    end else begin
      seq_data_addr <= addr_d;
      phase_cnt_q   <= phase_cnt_d;
      seq_valid     <= seq_valid_d;
      busy          <= busy_d;
      done          <= done_d;
      wht_valid     <= wht_valid_d;
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_weight_sequence_gen.sv
// Self-checking bench for the weight sequence generator: vector table, directed corners, random runs.
module tb_cnn_layer_accel_weight_sequence_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] cfg_num_phases;
  logic [1:0]  cfg_start_gray;
  logic        abort;
  logic        seq_ready;
  logic [1:0]  gray_code;
  logic [2:0]  seq_data_addr;
  logic        seq_valid;
  logic        wht_valid;
  logic        busy;
  logic        done;

  localparam int SEQ_LEN = 5;

  typedef struct {
    logic        start;
    logic [15:0] num;
    logic [1:0]  sg;
    logic        rdy;
    logic        ab;
    logic [8:0]  exp;
  } vec_t;

  int         vectors = 0;
  int         miscompares = 0;
  logic [4:0] held;
  logic [1:0] gseq [4];
  vec_t       tbl[$];

  cnn_layer_accel_weight_sequence_gen #(
    .C_SEQ_LEN     (SEQ_LEN),
    .C_PHASE_CNT_W (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_num_phases (cfg_num_phases),
    .cfg_start_gray (cfg_start_gray),
    .abort          (abort),
    .seq_ready      (seq_ready),
    .gray_code      (gray_code),
    .seq_data_addr  (seq_data_addr),
    .seq_valid      (seq_valid),
    .wht_valid      (wht_valid),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // exp = {gray[1:0], addr[2:0], seq_valid, wht_valid, busy, done}
  task automatic check(input string name, input logic [8:0] exp);
    logic [8:0] act;
    act = {gray_code, seq_data_addr, seq_valid, wht_valid, busy, done};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got g=%b a=%0d v=%b w=%b b=%b d=%b, expected g=%b a=%0d v=%b w=%b b=%b d=%b",
               name, act[8:7], act[6:4], act[3], act[2], act[1], act[0],
               exp[8:7], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic vec_t mk(logic s, logic [15:0] n, logic [1:0] g, logic r, logic ab,
                              logic [1:0] eg, logic [2:0] ea, logic [3:0] vwbd);
    mk.start = s;
    mk.num   = n;
    mk.sg    = g;
    mk.rdy   = r;
    mk.ab    = ab;
    mk.exp   = {eg, ea, vwbd};
  endfunction

  // Reference: the run is the list of (phase, addr) pairs in order; each cycle shows the
  // next unconsumed pair, wht_valid echoes last cycle's handshake.
  task automatic run_check(input int num, input logic [1:0] sg, input int unsigned pct,
                           input int abort_at, input int stall_idx, input bit spur);
    logic [4:0] pairs[$];
    int         k0, idx, hs_n, stall_left;
    logic       prev_hs, rdy, ab;
    bit         stalled, finished;
    k0 = 0;
    for (int i = 0; i < 4; i++) if (gseq[i] == sg) k0 = i;
    for (int p = 0; p < num; p++)
      for (int a = 0; a < SEQ_LEN; a++)
        pairs.push_back({gseq[(k0 + p) % 4], 3'(a)});

    start = 1'b1; cfg_num_phases = 16'(num); cfg_start_gray = sg; seq_ready = 1'b0; abort = 1'b0;
    step();
    start = 1'b0; cfg_num_phases = 16'($urandom); cfg_start_gray = 2'($urandom);
    if (num == 0) begin
      check("zero_done", {held, 4'b0001});
      step();
      check("zero_idle", {held, 4'b0000});
      return;
    end

    idx = 0; hs_n = 0; prev_hs = 1'b0; stalled = 1'b0; stall_left = 0; finished = 1'b0;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      if (idx < pairs.size()) begin
        check("run", {pairs[idx], 1'b1, prev_hs, 1'b1, 1'b0});
        rdy = ($urandom_range(0, 99) < pct);
        if (idx == stall_idx && !stalled) begin
          stalled = 1'b1;
          stall_left = 3;
        end
        if (stall_left > 0) begin
          rdy = 1'b0;
          stall_left--;
        end
        ab = (abort_at != 0) && rdy && (hs_n + 1 == abort_at);
        seq_ready = rdy;
        abort = ab;
        start = spur && ($urandom_range(0, 1) == 1);
        cfg_num_phases = 16'($urandom_range(0, 3));
        cfg_start_gray = 2'($urandom);
        step();
        start = 1'b0;
        abort = 1'b0;
        if (ab) begin
          check("abort", {pairs[idx], 4'b0000});
          step();
          check("abort_no_done", {pairs[idx], 4'b0000});
          held = pairs[idx];
          finished = 1'b1;
        end else begin
          prev_hs = rdy;
          if (rdy) begin
            idx++;
            hs_n++;
          end
        end
      end else begin
        check("done", {pairs[pairs.size()-1], 1'b0, prev_hs, 1'b0, 1'b1});
        step();
        check("idle_after_done", {pairs[pairs.size()-1], 4'b0000});
        held = pairs[pairs.size()-1];
        finished = 1'b1;
      end
    end
    seq_ready = 1'b0;
    if (!finished) begin
      vectors++;
      miscompares++;
      $display("FAIL run_timeout: got %0d handshakes, expected %0d", hs_n, pairs.size());
    end
  endtask

  initial begin
    gseq[0] = 2'b00; gseq[1] = 2'b01; gseq[2] = 2'b11; gseq[3] = 2'b10;

    tbl.push_back(mk(1'b1, 16'd1, 2'b11, 1'b1, 1'b0, 2'b11, 3'd0, 4'b1010));
    tbl.push_back(mk(1'b0, 16'd0, 2'b00, 1'b1, 1'b0, 2'b11, 3'd1, 4'b1110));
    tbl.push_back(mk(1'b0, 16'd0, 2'b00, 1'b1, 1'b0, 2'b11, 3'd2, 4'b1110));
    tbl.push_back(mk(1'b0, 16'd0, 2'b00, 1'b0, 1'b0, 2'b11, 3'd2, 4'b1010));
    tbl.push_back(mk(1'b0, 16'd0, 2'b00, 1'b1, 1'b0, 2'b11, 3'd3, 4'b1110));
    tbl.push_back(mk(1'b0, 16'd0, 2'b00, 1'b1, 1'b0, 2'b11, 3'd4, 4'b1110));
    tbl.push_back(mk(1'b0, 16'd0, 2'b00, 1'b1, 1'b0, 2'b11, 3'd4, 4'b0101));
    tbl.push_back(mk(1'b1, 16'd3, 2'b00, 1'b1, 1'b0, 2'b11, 3'd4, 4'b0000));
    tbl.push_back(mk(1'b1, 16'd0, 2'b11, 1'b0, 1'b0, 2'b11, 3'd4, 4'b0001));
    tbl.push_back(mk(1'b0, 16'd0, 2'b00, 1'b0, 1'b1, 2'b11, 3'd4, 4'b0000));

    rst = 1'b0; start = 1'b0; cfg_num_phases = '0; cfg_start_gray = '0;
    abort = 1'b0; seq_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 9'd0);
    rst = 1'b1;
    step();

    foreach (tbl[i]) begin
      start = tbl[i].start; cfg_num_phases = tbl[i].num; cfg_start_gray = tbl[i].sg;
      seq_ready = tbl[i].rdy; abort = tbl[i].ab;
      step();
      check($sformatf("tbl[%0d]", i), tbl[i].exp);
    end
    start = 1'b0; seq_ready = 1'b0; abort = 1'b0;
    held = {2'b11, 3'd4};

    run_check(4, 2'b00, 100, 0, -1, 1'b0);   // basic
    run_check(2, 2'b10, 100, 0, -1, 1'b0);   // wrap from 10
    run_check(4, 2'b00, 100, 0, 7, 1'b0);    // stall at phase 01 addr 2
    run_check(0, 2'b01, 100, 0, -1, 1'b0);   // zero phases
    run_check(4, 2'b01, 100, 0, -1, 1'b1);   // start pulses during run
    run_check(4, 2'b00, 100, 7, -1, 1'b0);   // abort at 7th handshake

    // Asynchronous reset mid-run at gray 11, addr 3.
    start = 1'b1; cfg_num_phases = 16'd4; cfg_start_gray = 2'b00;
    step();
    start = 1'b0; seq_ready = 1'b1;
    repeat (13) step();
    check("pre_reset", {2'b11, 3'd3, 4'b1110});
    rst = 1'b0;
    #1;
    check("reset_async", 9'd0);
    step();
    check("reset_hold", 9'd0);
    rst = 1'b1; seq_ready = 1'b0;
    held = 5'd0;
    step();
    check("reset_no_done", 9'd0);
    run_check(2, 2'b01, 100, 0, -1, 1'b0);

    for (int r = 0; r < 25; r++) begin
      int n;
      int ab_at;
      n = int'($urandom_range(0, 5));
      ab_at = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, n * SEQ_LEN)) : 0;
      run_check(n, 2'($urandom), $urandom_range(40, 100), ab_at,
                int'($urandom_range(0, 29)), ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
